rc5_key_expand: RTL and testbench
=================================

Name: rc5_key_expand

Overview:
- RC5-16/r/16 key-schedule engine, directly upstream of the rc5 cipher datapath.
- 32-bit d_in is one block of two 16-bit words, so w=16.
- On load_key it expands the 128-bit key into the round-key table S[0..2r+1], one step per cycle, then raises key_ready.
- The cipher core reads S through a single combinational read port.

Parameters:
- W, 16, word width in bits (fixed by the block size; not meant to be overridden).
- MAX_ROUNDS, 31, largest supported num_rounds; table depth = 2*(MAX_ROUNDS+1) = 64.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_key  in  1  start expansion; one-cycle pulse or level.
- key  in  128  secret key; byte K[0] = key[127:120] through K[15] = key[7:0].
- num_rounds  in  5  round count r, 0..31.
- key_ready  out  1  table valid for current key/r.
- busy  out  1  expansion in progress.
- s_rd_addr  in  6  round-key index.
- s_rd_data  out  16  S[s_rd_addr] (combinational).

Behaviour:
- Reset (async, rst_n=0): state IDLE, key_ready=0, busy=0, s_rd_data=0, every S entry=0, every L entry=0, A=B=0, all counters 0.
- t = 2*(r+1) (2..64); c = 8; mix count N = 3*max(t,c).
- States:
  - IDLE
  - INIT: S[i] = P16 + i*Q16 mod 2^16, where P16=0xB7E1 and Q16=0x9E37. One entry per cycle, i = 0..t-1.
  - MIX: one step per cycle.
    - A' = S[i] = ROTL(S[i]+A+B, 3).
    - B' = L[j] = ROTL(L[j]+A'+B, (A'+B) mod 16).
    - i wraps at t, j wraps at c, k counts 0..N-1.
    - All sums are mod 2^16.
  - DONE
- Accept and load:
  - load_key is accepted in IDLE or DONE only.
  - On accept, key and num_rounds are latched, L[m] = {K[2m+1], K[2m]} for m=0..7, A=B=0, i=j=k=0, and the state goes to INIT.
  - key_ready falls and busy rises in the cycle after accept.
- Transitions: INIT → MIX after t cycles; MIX → DONE after N cycles.
- On DONE entry, key_ready=1 and busy=0.
- Latency from the accept edge to key_ready=1 is t + N + 1 cycles. Examples: r=0 gives 27; r=12 gives 105; r=31 gives 257.
- load_key is ignored while busy; the latched key and r are unaffected.
- load_key asserted in DONE re-expands the table; key_ready drops the next cycle.
- s_rd_data = S[s_rd_addr] when key_ready=1, else 0.
- Addresses ≥ t return the stale or zero table content; the consumer must not use them.
- Changing key or num_rounds without load_key has no effect.
- rst_n asserted mid-expansion aborts immediately to the reset state.

Optional Feature:
- Macro: RC5_KEY_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - A zeroize high in any state clears all S, L, A and B to 0, forces key_ready=0 and busy=0, and enters IDLE on the next edge.
  - zeroize has priority over load_key in the same cycle.
  - On DONE entry, L and A/B are also cleared so no key-derived residue remains.
- Undefined: no zeroize port; L, A and B keep their final values until the next accept or reset.

Decomposition:
- Package rc5_pkg holds:
  - W, P16, Q16, C_WORDS=8, MAX_T=64.
  - typedef word_t (logic [15:0]).
  - typedef enum ks_state_t {IDLE, INIT, MIX, DONE}.
  - Function t_of(r).
- Sub-module rc5_rotl: combinational rotate-left of a W-bit word by a log2(W)-bit amount. It is instantiated twice in the MIX step and is reused by the cipher core.

Test Plan:
1. Reset, then key=0, r=0, one-cycle load_key → busy=1 the next cycle; key_ready=1 exactly 27 cycles after the accept edge; S[0], S[1] match the C reference model for RC5-16/0/16.
2. Key=0x2B7E151628AED2A6ABF7158809CF4F3C, r=31 → key_ready after 257 cycles; all 64 entries read via s_rd_addr match the golden model; s_rd_data=0 at every sample while busy.
3. Mid-expansion checks:
   - load_key re-pulsed with a different key at cycle 10 of a r=12 run → ignored; key_ready at cycle 105; table matches the first key.
   - Then load_key in DONE with r=1 → key_ready low next cycle, high 4+24+1=29 cycles later.
4. Mid-MIX reset: assert rst_n=0 asynchronously (between edges) during MIX → key_ready=0, busy=0 and s_rd_data=0 immediately; a subsequent load_key with key=0, r=0 completes normally in 27 cycles.
5. Init check (white-box): r=31 run; sample S at INIT→MIX transition → S[1]=0x5618, S[2]=0xF44F, S[63]=P16+63*Q16 mod 2^16.
6. With RC5_KEY_ZEROIZE_EN: zeroize in DONE → next cycle key_ready=0, all S reads 0 after a new load; zeroize and load_key in the same cycle → IDLE, no expansion started.

Source files
------------

// File: rtl/rc5_pkg.sv
// rc5_pkg: shared word type, magic constants and state encoding for the RC5-16 key schedule and cipher.
package rc5_pkg;
    localparam int W = 16;
    localparam int C_WORDS = 8;
    localparam int MAX_T = 64;
    typedef logic [W-1:0] word_t;
    localparam word_t P16 = 16'hB7E1;
    localparam word_t Q16 = 16'h9E37;
    typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} ks_state_t;
    function automatic logic [6:0] t_of(input logic [4:0] r);
        return {1'b0, r, 1'b0} + 7'd2;
    endfunction
endpackage

// File: rtl/rc5_rotl.sv
// rc5_rotl: combinational rotate-left of a W-bit word, shared by the key schedule and the cipher core.
module rc5_rotl #(
    parameter int W = 16
) (
    input  logic [W-1:0]         x,
    input  logic [$clog2(W)-1:0] amt,
    output logic [W-1:0]         y
);
    assign y = (x << amt) | (x >> (W - 32'(amt)));
endmodule

// File: rtl/rc5_key_expand.sv
// rc5_key_expand: RC5-16/r/16 key schedule filling S[0..2r+1], one INIT or MIX step per clock.
// Define RC5_KEY_ZEROIZE_EN to add a zeroize input and wipe L/A/B once the table is complete.
module rc5_key_expand
    import rc5_pkg::*;
#(
    parameter int MAX_ROUNDS = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_key,
`ifdef RC5_KEY_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic [127:0] key,
    input  logic [4:0]   num_rounds,
    output logic         key_ready,
    output logic         busy,
    input  logic [5:0]   s_rd_addr,
    output logic [15:0]  s_rd_data
);
    localparam int DEPTH = 2 * (MAX_ROUNDS + 1);

    ks_state_t  state_q, state_d;
    word_t      s_q [DEPTH];
    word_t      s_d [DEPTH];
    word_t      l_q [C_WORDS];
    word_t      l_d [C_WORDS];
    word_t      a_q, a_d, b_q, b_d;
    logic [5:0] i_q, i_d;
    logic [2:0] j_q, j_d;
    logic [7:0] k_q, k_d;
    logic [4:0] r_q, r_d;
    logic       key_ready_q, key_ready_d, busy_q, busy_d;

    logic [6:0] t_cur;
    logic [7:0] t_max, n_last;
    logic       i_last, k_last, accept;
    word_t      init_val, sum_a, a_new, ab_sum, sum_b, b_new;

    assign t_cur    = t_of(r_q);
    assign t_max    = (t_cur > 7'd8) ? {1'b0, t_cur} : 8'd8;
    assign n_last   = t_max + (t_max << 1) - 8'd1;
    assign i_last   = {1'b0, i_q} == t_cur - 7'd1;
    assign k_last   = k_q == n_last;
    assign accept   = load_key && !busy_q && (state_q == IDLE || state_q == DONE);
    assign init_val = P16 + Q16 * word_t'(i_q);

    assign sum_a = s_q[i_q] + a_q + b_q;
    rc5_rotl #(.W(W)) u_rotl_a (.x(sum_a), .amt(4'd3), .y(a_new));
    // B's rotate amount depends on the freshly computed A, so both rotates chain in one cycle.
    assign ab_sum = a_new + b_q;
    assign sum_b  = l_q[j_q] + ab_sum;
    rc5_rotl #(.W(W)) u_rotl_b (.x(sum_b), .amt(ab_sum[3:0]), .y(b_new));

    assign key_ready = key_ready_q;
    assign busy      = busy_q;
    assign s_rd_data = key_ready_q ? s_q[s_rd_addr] : '0;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        l_d         = l_q;
        a_d         = a_q;
        b_d         = b_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        r_d         = r_q;
        key_ready_d = key_ready_q;
        busy_d      = busy_q;
        case (state_q)
            INIT: begin
                s_d[i_q] = init_val;
                i_d      = i_last ? '0 : i_q + 6'd1;
                state_d  = i_last ? MIX : INIT;
            end
            MIX: begin
                s_d[i_q] = a_new;
                l_d[j_q] = b_new;
                a_d      = a_new;
                b_d      = b_new;
                i_d      = i_last ? '0 : i_q + 6'd1;
                j_d      = j_q + 3'd1;
                k_d      = k_q + 8'd1;
                state_d  = k_last ? DONE : MIX;
            end
            DONE: begin
                // First DONE cycle publishes the table; later cycles just hold it.
                if (busy_q) begin
                    busy_d      = 1'b0;
                    key_ready_d = 1'b1;
`ifdef RC5_KEY_ZEROIZE_EN
                    for (int m = 0; m < C_WORDS; m++) l_d[m] = '0;
                    a_d = '0;
                    b_d = '0;
`endif
                end
            end
            default: ;
        endcase
        if (accept) begin
            for (int m = 0; m < C_WORDS; m++) l_d[m] = {key[119-16*m -: 8], key[127-16*m -: 8]};
            r_d         = num_rounds;
            a_d         = '0;
            b_d         = '0;
            i_d         = '0;
            j_d         = '0;
            k_d         = '0;
            state_d     = INIT;
            busy_d      = 1'b1;
            key_ready_d = 1'b0;
        end
`ifdef RC5_KEY_ZEROIZE_EN
        if (zeroize) begin
            for (int n = 0; n < DEPTH; n++) s_d[n] = '0;
            for (int m = 0; m < C_WORDS; m++) l_d[m] = '0;
            a_d         = '0;
            b_d         = '0;
            i_d         = '0;
            j_d         = '0;
            k_d         = '0;
            state_d     = IDLE;
            busy_d      = 1'b0;
            key_ready_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int n = 0; n < DEPTH; n++) s_q[n] <= '0;
            for (int m = 0; m < C_WORDS; m++) l_q[m] <= '0;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            r_q         <= '0;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            l_q         <= l_d;
            a_q         <= a_d;
            b_q         <= b_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            r_q         <= r_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_rc5_key_expand.sv
// tb_rc5_key_expand: directed stimulus with a scoreboard queue drained by an independent negedge monitor.
// Expected tables come from a behavioural RC5-16 key schedule; latencies from t + 3*max(t,8) + 1.
module tb_rc5_key_expand;
    import rc5_pkg::*;

    typedef struct {int sel; int addr; logic [15:0] exp;} item_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_key = 1'b0;
`ifdef RC5_KEY_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif
    logic [127:0] key_i = '0;
    logic [4:0]   nr = '0;
    logic         key_ready, busy;
    logic [5:0]   s_rd_addr = 6'd1;
    logic [15:0]  s_rd_data;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic         smp = 1'b0;
    logic         kr_prev = 1'b0;
    int           rdyq[$];
    item_t        sbq[$];
    logic [15:0]  gold [64];
    item_t        mon_it;
    int           mon_e;
    logic [15:0]  mon_got;

    localparam logic [127:0] KEY_A = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090A0B0C0D0E0F;

    rc5_key_expand dut (
        .clk(clk), .rst_n(rst_n), .load_key(load_key),
`ifdef RC5_KEY_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key(key_i), .num_rounds(nr), .key_ready(key_ready), .busy(busy),
        .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        logic [31:0] d;
        d = {v, v};
        return d[31-n -: 16];
    endfunction

    function automatic int lat(input int r);
        int t;
        t = 2 * (r + 1);
        return t + 3 * ((t > 8) ? t : 8) + 1;
    endfunction

    function automatic string name_of(input int sel);
        return sel == 0 ? "s_rd_data" : sel == 1 ? "busy" : sel == 2 ? "key_ready" : "s_table";
    endfunction

    task automatic compute_gold(input logic [127:0] k, input int r);
        logic [7:0]  kb [16];
        logic [15:0] l [8];
        logic [15:0] a, b;
        int t, n, ii, jj;
        t = 2 * (r + 1);
        n = 3 * ((t > 8) ? t : 8);
        for (int x = 0; x < 16; x++) kb[x] = k[127-8*x -: 8];
        for (int m = 0; m < 8; m++) l[m] = 16'(kb[2*m]) + (16'(kb[2*m+1]) << 8);
        for (int x = 0; x < 64; x++) gold[x] = (x < t) ? 16'(32'hB7E1 + x * 32'h9E37) : 16'h0;
        a = 0; b = 0; ii = 0; jj = 0;
        for (int s = 0; s < n; s++) begin
            a = rotl(gold[ii] + a + b, 3);
            gold[ii] = a;
            b = rotl(l[jj] + a + b, (a + b) % 16);
            l[jj] = b;
            ii = (ii + 1) % t;
            jj = (jj + 1) % 8;
        end
    endtask

    task automatic push(input int sel, input int addr, input logic [15:0] exp);
        item_t it;
        it.sel = sel; it.addr = addr; it.exp = exp;
        sbq.push_back(it);
    endtask

    task automatic fire();
        smp = 1'b1;
        @(negedge clk);
        #1 smp = 1'b0;
    endtask

    task automatic load(input logic [127:0] k, input int r);
        @(negedge clk);
        key_i = k;
        nr = 5'(r);
        load_key = 1'b1;
        rdyq.push_back(cyc + 1 + lat(r));
        @(posedge clk);
        #1 load_key = 1'b0;
        push(1, 0, 16'h1);
        push(2, 0, 16'h0);
        fire();
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!key_ready && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        push(2, 0, 16'h1);
        fire();
    endtask

    task automatic wait_mix();
        int n;
        n = 0;
        while (dut.state_q != MIX && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic read_table(input int t);
        for (int a = 0; a < t; a++) begin
            @(posedge clk);
            #1 s_rd_addr = 6'(a);
            push(0, a, gold[a]);
            fire();
        end
        s_rd_addr = 6'd1;
    endtask

    initial forever begin
        @(negedge clk);
        if (busy) begin
            checks++;
            if (s_rd_data !== 16'h0) begin
                errors++;
                $display("FAIL rd_while_busy got %h exp 0000 at cycle %0d", s_rd_data, cyc);
            end
        end
        if (key_ready && !kr_prev) begin
            checks++;
            if (rdyq.size() == 0) begin
                errors++;
                $display("FAIL ready_cycle got %0d exp none", cyc);
            end else begin
                mon_e = rdyq.pop_front();
                if (cyc != mon_e) begin
                    errors++;
                    $display("FAIL ready_cycle got %0d exp %0d", cyc, mon_e);
                end
            end
        end
        kr_prev = key_ready;
        if (smp) while (sbq.size() > 0) begin
            mon_it = sbq.pop_front();
            case (mon_it.sel)
                0: mon_got = s_rd_data;
                1: mon_got = {15'b0, busy};
                2: mon_got = {15'b0, key_ready};
                default: mon_got = dut.s_q[mon_it.addr];
            endcase
            checks++;
            if (mon_got !== mon_it.exp) begin
                errors++;
                $display("FAIL %s[%0d] got %h exp %h", name_of(mon_it.sel), mon_it.addr, mon_got, mon_it.exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 push(2, 0, 16'h0);
        push(1, 0, 16'h0);
        push(0, 1, 16'h0);
        fire();
        rst_n = 1'b1;
        // r=0, zero key: 27-cycle latency, S[0..1] against the model
        load('0, 0);
        wait_ready();
        compute_gold('0, 0);
        read_table(2);
        // r=31: INIT contents at the INIT->MIX boundary, then the full table
        load(KEY_A, 31);
        wait_mix();
        push(3, 1, 16'h5618);
        push(3, 2, 16'hF44F);
        push(3, 63, 16'hA76A);
        fire();
        wait_ready();
        compute_gold(KEY_A, 31);
        read_table(64);
        // r=12 with an ignored re-pulse, then a re-expand from DONE with r=1
        load(KEY_B, 12);
        repeat (8) @(posedge clk);
        @(negedge clk);
        key_i = KEY_A;
        nr = 5'd5;
        load_key = 1'b1;
        @(posedge clk);
        #1 load_key = 1'b0;
        wait_ready();
        compute_gold(KEY_B, 12);
        read_table(26);
        load(KEY_A, 1);
        wait_ready();
        compute_gold(KEY_A, 1);
        read_table(4);
        // asynchronous reset in the middle of MIX
        load(KEY_B, 12);
        wait_mix();
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        rdyq.delete();
        #1 push(2, 0, 16'h0);
        push(1, 0, 16'h0);
        push(0, 1, 16'h0);
        push(3, 5, 16'h0);
        fire();
        @(posedge clk);
        #1 rst_n = 1'b1;
        load('0, 0);
        wait_ready();
        compute_gold('0, 0);
        read_table(2);
`ifdef RC5_KEY_ZEROIZE_EN
        @(posedge clk);
        #1 zeroize = 1'b1;
        @(posedge clk);
        #1 zeroize = 1'b0;
        push(2, 0, 16'h0);
        push(1, 0, 16'h0);
        for (int a = 0; a < 4; a++) push(3, a, 16'h0);
        fire();
        @(negedge clk);
        load_key = 1'b1;
        zeroize = 1'b1;
        @(posedge clk);
        #1 load_key = 1'b0;
        zeroize = 1'b0;
        push(1, 0, 16'h0);
        push(2, 0, 16'h0);
        fire();
        repeat (3) @(posedge clk);
        #1 push(1, 0, 16'h0);
        fire();
`endif
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
